// File: rtl/main_mem_ctrl_pkg.sv
// Shared encodings for the main-memory controller: bus request types and FSM states.
package main_mem_ctrl_pkg;

    localparam int IOSTATEWIDTH = 2;

    localparam logic [IOSTATEWIDTH-1:0] IO_IDLE  = 2'b00;
    localparam logic [IOSTATEWIDTH-1:0] IO_READ  = 2'b01;
    localparam logic [IOSTATEWIDTH-1:0] IO_WRITE = 2'b10;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_WAIT = 2'b01,
        MS_RESP = 2'b10,
        MS_HOLD = 2'b11
    } memState_t;

endpackage

// File: rtl/main_mem_ctrl_mem_array.sv
// Single-port word RAM: synchronous write, combinational read. Contents are never reset,
// so a hierarchical preload survives controller resets.
module main_mem_ctrl_mem_array #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_addr];

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory controller: accepts one read/write from memBus, waits LATENCY cycles,
// answers with a one-cycle pulse, then waits for the request to be released.
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int WORD_W    = 16,
    parameter int MEM_DEPTH = 256,
    parameter int LATENCY   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rwFromBus,
    input  logic [ADDR_W-1:0]       addrFromBus,
    input  logic [WORD_W-1:0]       dataFromBus,
    output logic [WORD_W-1:0]       dataToBus,
    output logic                    rdEnToBus,
    output logic                    wbDoneToBus,
    output logic                    busy,
    output logic                    errAddr
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);

    memState_t                r_state;
    memState_t                w_nextState;
    logic [CNT_W-1:0]         r_cnt;
    logic [IOSTATEWIDTH-1:0]  r_rw;
    logic [ADDR_W-1:0]        r_addr;
    logic [WORD_W-1:0]        r_data;
    logic [WORD_W-1:0]        r_dataOut;
    logic                     r_rdEn;
    logic                     r_wbDone;
    logic                     r_err;

    logic                     w_accept;
    logic                     w_inRange;
    logic                     w_memWe;
    logic [IDX_W-1:0]         w_idx;
    logic [WORD_W-1:0]        w_memRd;

    assign w_accept  = (rwFromBus == IO_READ) || (rwFromBus == IO_WRITE);
    assign w_inRange = ({1'b0, r_addr} < DEPTH_L);
    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_memWe   = (r_state == MS_RESP) && (r_rw == IO_WRITE) && w_inRange;

    main_mem_ctrl_mem_array #(
        .WORD_W (WORD_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_memArray (
        .clk     (clk),
        .i_we    (w_memWe),
        .i_addr  (w_idx),
        .i_wdata (r_data),
        .o_rdata (w_memRd)
    );

    // The counter holds the cycles still to wait; leaving WAIT when it would reach zero
    // puts the registered response pulse exactly LATENCY edges after acceptance.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MS_IDLE: begin
                if (w_accept) begin
                    w_nextState = (LATENCY == 1) ? MS_RESP : MS_WAIT;
                end
            end
            MS_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_nextState = MS_RESP;
                end
            end
            MS_RESP: begin
                w_nextState = MS_HOLD;
            end
            MS_HOLD: begin
                if (rwFromBus == IO_IDLE) begin
                    w_nextState = MS_IDLE;
                end
            end
            default: begin
                w_nextState = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= MS_IDLE;
            r_cnt     <= '0;
            r_rw      <= IO_IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_dataOut <= '0;
            r_rdEn    <= 1'b0;
            r_wbDone  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_rdEn   <= 1'b0;
            r_wbDone <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                MS_IDLE: begin
                    if (w_accept) begin
                        r_rw   <= rwFromBus;
                        r_addr <= addrFromBus;
                        r_data <= dataFromBus;
                        r_cnt  <= CNT_LOAD;
                    end
                end
                MS_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                // Out-of-range reads return zero rather than an aliased word.
                MS_RESP: begin
                    r_err <= !w_inRange;
                    if (r_rw == IO_READ) begin
                        r_rdEn    <= 1'b1;
                        r_dataOut <= w_inRange ? w_memRd : '0;
                    end else begin
                        r_wbDone  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dataToBus   = r_dataOut;
    assign rdEnToBus   = r_rdEn;
    assign wbDoneToBus = r_wbDone;
    assign errAddr     = r_err;
    assign busy        = (r_state != MS_IDLE);

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Self-checking bench for main_mem_ctrl: a LATENCY=4 instance driven from a vector table,
// hand-written corner sequences and random traffic, plus a LATENCY=1 instance.
module tb_main_mem_ctrl;
    import main_mem_ctrl_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;

    logic [1:0]  rw0, rw1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic [15:0] rdata0, rdata1;
    logic        rdEn0, rdEn1, wbDone0, wbDone1, busy0, busy1, err0, err1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] refMem [0:DEPTH-1];
    logic [15:0] lastRead0;

    typedef struct {
        logic [1:0]  rw;
        logic [15:0] addr;
        logic [15:0] data;
        int          hold;
        bit          expRd;
        bit          expWb;
        bit          expErr;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    main_mem_ctrl #(.ADDR_W(16), .WORD_W(16), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut0 (
        .clk         (clk),
        .reset       (reset),
        .rwFromBus   (rw0),
        .addrFromBus (addr0),
        .dataFromBus (wdata0),
        .dataToBus   (rdata0),
        .rdEnToBus   (rdEn0),
        .wbDoneToBus (wbDone0),
        .busy        (busy0),
        .errAddr     (err0)
    );

    main_mem_ctrl #(.ADDR_W(16), .WORD_W(16), .MEM_DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .rwFromBus   (rw1),
        .addrFromBus (addr1),
        .dataFromBus (wdata1),
        .dataToBus   (rdata1),
        .rdEnToBus   (rdEn1),
        .wbDoneToBus (wbDone1),
        .busy        (busy1),
        .errAddr     (err1)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic checkPort0(input string tag, input bit expRd, input bit expWb,
                              input bit expErr, input bit expBusy, input logic [15:0] expData);
        checkOutput({tag, "_rdEn"},   32'(rdEn0),   32'(expRd));
        checkOutput({tag, "_wbDone"}, 32'(wbDone0), 32'(expWb));
        checkOutput({tag, "_err"},    32'(err0),    32'(expErr));
        checkOutput({tag, "_busy"},   32'(busy0),   32'(expBusy));
        checkOutput({tag, "_data"},   32'(rdata0),  32'(expData));
    endtask

    // Reference behaviour: one request, one response, word array with hard bounds.
    task automatic modelTxn(input logic [1:0] rw, input logic [15:0] addr, input logic [15:0] data,
                            output bit expRd, output bit expWb, output bit expErr,
                            output logic [15:0] expData);
        expErr  = (int'(addr) >= DEPTH);
        expRd   = (rw == IO_READ);
        expWb   = (rw == IO_WRITE);
        expData = 16'h0000;
        if (expRd && !expErr) expData = refMem[addr[7:0]];
        if (expWb && !expErr) refMem[addr[7:0]] = data;
    endtask

    // Drives one request on dut0 and checks every cycle until the controller is idle again.
    // holdCycles==0 drops the request right after acceptance; otherwise it stays level-held.
    task automatic applyStimulus(input logic [1:0] rw, input logic [15:0] addr, input logic [15:0] data,
                                 input int holdCycles, input bit scramble,
                                 input bit expRd, input bit expWb, input bit expErr,
                                 input logic [15:0] expData);
        @(negedge clk);
        rw0    = rw;
        addr0  = addr;
        wdata0 = data;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            if (holdCycles == 0) rw0 = IO_IDLE;
            if (scramble) begin
                addr0  = 16'($urandom);
                wdata0 = 16'($urandom);
            end
            checkPort0("wait", 1'b0, 1'b0, 1'b0, 1'b1, lastRead0);
        end
        @(negedge clk);
        checkPort0("resp", expRd, expWb, expErr, 1'b1, expRd ? expData : lastRead0);
        if (expRd) lastRead0 = expData;
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clk);
            checkPort0("hold", 1'b0, 1'b0, 1'b0, 1'b1, lastRead0);
        end
        rw0 = IO_IDLE;
        @(negedge clk);
        checkPort0("idle", 1'b0, 1'b0, 1'b0, 1'b0, lastRead0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          eRd, eWb, eErr;
        logic [15:0] eData;
        int          pulses;
        bit          prevPulse;
        bit          wbSeen;

        vecs[0]  = '{IO_WRITE, 16'd5,    16'h00A5, 0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{IO_READ,  16'd5,    16'h0000, 2, 1'b1, 1'b0, 1'b0, 16'h00A5};
        vecs[2]  = '{IO_WRITE, 16'd0,    16'h0003, 1, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[3]  = '{IO_READ,  16'd0,    16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h0003};
        vecs[4]  = '{IO_WRITE, 16'd300,  16'h0007, 0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[5]  = '{IO_READ,  16'd300,  16'h0000, 1, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[6]  = '{IO_READ,  16'd44,   16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h102C};
        vecs[7]  = '{IO_WRITE, 16'd255,  16'hFFFF, 0, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[8]  = '{IO_READ,  16'd255,  16'h0000, 3, 1'b1, 1'b0, 1'b0, 16'hFFFF};
        vecs[9]  = '{IO_READ,  16'd256,  16'h0000, 0, 1'b1, 1'b0, 1'b1, 16'h0000};
        vecs[10] = '{IO_WRITE, 16'hFFFF, 16'h0001, 0, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[11] = '{IO_READ,  16'h00FF, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'hFFFF};
        vecs[12] = '{IO_WRITE, 16'h8005, 16'h0001, 2, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[13] = '{IO_READ,  16'd5,    16'h0000, 0, 1'b1, 1'b0, 1'b0, 16'h00A5};

        reset  = 1'b0;
        rw0    = IO_IDLE; addr0 = '0; wdata0 = '0;
        rw1    = IO_IDLE; addr1 = '0; wdata1 = '0;
        lastRead0 = 16'h0000;

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        checkPort0("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("reset1_busy", 32'(busy1), 32'd0);
        checkOutput("reset1_data", 32'(rdata1), 32'd0);
        checkOutput("reset1_pulses", {29'd0, rdEn1, wbDone1, err1}, 32'd0);
        reset = 1'b1;

        // Give the array a known image through the bus.
        for (int a = 0; a < DEPTH; a++) begin
            modelTxn(IO_WRITE, 16'(a), 16'(16'h1000 + a), eRd, eWb, eErr, eData);
            applyStimulus(IO_WRITE, 16'(a), 16'(16'h1000 + a), 0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        end

        for (int i = 0; i < 14; i++) begin
            modelTxn(vecs[i].rw, vecs[i].addr, vecs[i].data, eRd, eWb, eErr, eData);
            applyStimulus(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].hold, 1'b1,
                          vecs[i].expRd, vecs[i].expWb, vecs[i].expErr, vecs[i].expData);
        end

        // Level-held read for 20 cycles yields exactly one response.
        @(negedge clk);
        rw0 = IO_READ; addr0 = 16'd7;
        pulses = 0; prevPulse = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rdEn0) begin
                pulses++;
                checkOutput("t3_data", 32'(rdata0), 32'h1007);
            end
            if (rdEn0 && prevPulse) checkOutput("t3_backToBack", 32'd1, 32'd0);
            if (wbDone0) checkOutput("t3_spuriousWb", 32'(wbDone0), 32'd0);
            prevPulse = rdEn0;
        end
        checkOutput("t3_pulseCount", 32'(pulses), 32'd1);
        checkOutput("t3_busyHeld", 32'(busy0), 32'd1);
        rw0 = IO_IDLE;
        @(negedge clk);
        checkOutput("t3_busyDrop", 32'(busy0), 32'd0);
        lastRead0 = 16'h1007;

        // Reset two edges into a write: nothing commits, outputs clear.
        @(negedge clk);
        rw0 = IO_WRITE; addr0 = 16'd9; wdata0 = 16'hBEEF;
        @(negedge clk);
        checkOutput("t5_busyBefore", 32'(busy0), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rw0   = IO_IDLE;
        @(negedge clk);
        lastRead0 = 16'h0000;
        checkPort0("t5_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        wbSeen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wbDone0) wbSeen = 1'b1;
        end
        checkOutput("t5_noWbDone", 32'(wbSeen), 32'd0);
        reset = 1'b1;
        applyStimulus(IO_READ, 16'd9, 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1009);

        // LATENCY=1 instance: illegal request ignored, single-cycle turnaround.
        @(negedge clk);
        rw1 = 2'b11; addr1 = 16'd3;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_illegalBusy", 32'(busy1), 32'd0);
        end
        rw1 = IO_WRITE; addr1 = 16'd3; wdata1 = 16'h1234;
        @(negedge clk);
        checkOutput("t6_wrBusy", 32'(busy1), 32'd1);
        checkOutput("t6_wrEarly", 32'(wbDone1), 32'd0);
        @(negedge clk);
        checkOutput("t6_wbDone", 32'(wbDone1), 32'd1);
        checkOutput("t6_wrErr", 32'(err1), 32'd0);
        rw1 = IO_IDLE;
        @(negedge clk);
        checkOutput("t6_wbDrop", 32'(wbDone1), 32'd0);
        checkOutput("t6_idleBusy", 32'(busy1), 32'd0);
        rw1 = IO_READ; addr1 = 16'd3;
        @(negedge clk);
        checkOutput("t6_rdEarly", 32'(rdEn1), 32'd0);
        @(negedge clk);
        checkOutput("t6_rdEn", 32'(rdEn1), 32'd1);
        checkOutput("t6_rdData", 32'(rdata1), 32'h1234);
        rw1 = IO_IDLE;
        @(negedge clk);
        checkOutput("t6_rdDrop", 32'(rdEn1), 32'd0);

        // Random traffic against the reference array.
        for (int n = 0; n < 80; n++) begin
            logic [1:0]  rRw;
            logic [15:0] rAddr, rData;
            rRw   = ($urandom_range(0, 1) == 0) ? IO_READ : IO_WRITE;
            rAddr = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
            rData = 16'($urandom);
            modelTxn(rRw, rAddr, rData, eRd, eWb, eErr, eData);
            applyStimulus(rRw, rAddr, rData, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          eRd, eWb, eErr, eData);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
